adc_capture_ctrl: RTL and testbench

Capture sequencer for the ADC-to-AXIS converter, clocked in the 125 MHz AXIS domain. Arms on a software start, optionally waits for a trigger, and enables the converter's ADC-side and AXIS-side controls. Passes the converter's AXIS stream downstream, framing it into packets with generated tlast, and stops after a programmed packet count. After each capture it drains stale FIFO contents, and it flags FIFO overflow.

---
 rtl/adc_capture_pkg.sv | 13 +
 rtl/cdc_sync_2ff.sv | 22 ++
 rtl/adc_capture_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// rtl/adc_capture_pkg.sv - state encoding and default sizing for the ADC capture sequencer
package adc_capture_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARMED = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int CNT_W_DEFAULT      = 16;
    localparam int FLUSH_IDLE_DEFAULT = 8;

endpackage

// File: rtl/cdc_sync_2ff.sv
// rtl/cdc_sync_2ff.sv - single-bit two-flop synchronizer with async active-low reset
module cdc_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first stage a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// rtl/adc_capture_ctrl.sv - capture sequencer framing the converter AXIS stream into counted packets
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEFAULT,
    parameter int FLUSH_IDLE = FLUSH_IDLE_DEFAULT
) (
    input  logic             m_axis_aclk,
    input  logic             m_axis_aresetn,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_trig_en,
    input  logic             i_trig,
    input  logic [CNT_W-1:0] i_pkt_len,
    input  logic [CNT_W-1:0] i_num_pkts,
    input  logic             i_fifo_full,
    output logic             o_con_adcside,
    output logic             o_con_axisside,
    input  logic             s_axis_tvalid,
    input  logic [63:0]      s_axis_tdata,
    output logic             s_axis_tready,
    output logic             m_axis_tvalid,
    output logic [63:0]      m_axis_tdata,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_overflow,
    output logic             o_aborted,
    output logic             o_err
);

    localparam logic [7:0]       FLUSH_IDLE_C = 8'(FLUSH_IDLE);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] pkt_len_q;
    logic [CNT_W-1:0] num_pkts_q;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] pkt_cnt;
    logic [7:0]       idle_cnt;
    logic             trig_sync;
    logic             fifo_full_sync;
    logic             trig_prev;
    logic             trig_edge;
    logic             overflow_q;
    logic             aborted_q;
    logic             err_q;
    logic             start_ok;
    logic             start_bad;
    logic             beat_fire;
    logic             pkt_last;
    logic             cap_last;

    cdc_sync_2ff u_sync_trig (
        .clk   (m_axis_aclk),
        .rst_n (m_axis_aresetn),
        .d     (i_trig),
        .q     (trig_sync)
    );

    cdc_sync_2ff u_sync_fifo_full (
        .clk   (m_axis_aclk),
        .rst_n (m_axis_aresetn),
        .d     (i_fifo_full),
        .q     (fifo_full_sync)
    );

    assign start_bad = i_start && (state == ST_IDLE) && ((i_pkt_len == '0) || (i_num_pkts == '0));
    assign start_ok  = i_start && (state == ST_IDLE) && (i_pkt_len != '0) && (i_num_pkts != '0);
    assign beat_fire = (state == ST_RUN) && s_axis_tvalid && m_axis_tready;
    assign pkt_last  = (beat_cnt == (pkt_len_q - CNT_ONE));
    assign cap_last  = pkt_last && (pkt_cnt == (num_pkts_q - CNT_ONE));

    // Registered rising-edge detect on the synchronized trigger.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            trig_prev <= 1'b0;
            trig_edge <= 1'b0;
        end else begin
            trig_prev <= trig_sync;
            trig_edge <= trig_sync && !trig_prev;
        end
    end

    // State register.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the final beat of a capture takes priority over a coincident abort.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (i_abort) begin
                    state_nxt = ST_FLUSH;
                end else if (!i_trig_en || trig_edge) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if ((beat_fire && cap_last) || i_abort) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!s_axis_tvalid && (idle_cnt == (FLUSH_IDLE_C - 8'd1))) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode; the stream is only connected through while running.
    always_comb begin
        o_con_adcside  = 1'b0;
        o_con_axisside = 1'b0;
        s_axis_tready  = 1'b0;
        m_axis_tvalid  = 1'b0;
        m_axis_tdata   = '0;
        m_axis_tlast   = 1'b0;
        o_done         = 1'b0;
        case (state)
            ST_RUN: begin
                o_con_adcside  = 1'b1;
                o_con_axisside = 1'b1;
                m_axis_tvalid  = s_axis_tvalid;
                m_axis_tdata   = s_axis_tdata;
                m_axis_tlast   = pkt_last;
                s_axis_tready  = m_axis_tready;
            end
            ST_FLUSH: begin
                o_con_axisside = 1'b1;
                s_axis_tready  = 1'b1;
            end
            ST_DONE: begin
                o_done = 1'b1;
            end
            default: begin
                o_done = 1'b0;
            end
        endcase
    end

    // Latched capture geometry and beat/packet counters.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            pkt_len_q  <= '0;
            num_pkts_q <= '0;
            beat_cnt   <= '0;
            pkt_cnt    <= '0;
        end else if (start_ok) begin
            pkt_len_q  <= i_pkt_len;
            num_pkts_q <= i_num_pkts;
            beat_cnt   <= '0;
            pkt_cnt    <= '0;
        end else if (beat_fire) begin
            if (pkt_last) begin
                beat_cnt <= '0;
                pkt_cnt  <= pkt_cnt + CNT_ONE;
            end else begin
                beat_cnt <= beat_cnt + CNT_ONE;
            end
        end
    end

    // Consecutive-idle counter that decides when the FIFO is drained.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            idle_cnt <= '0;
        end else if ((state != ST_FLUSH) || s_axis_tvalid) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 8'd1;
        end
    end

    // Sticky status; an accepted start wipes the previous capture's history.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            overflow_q <= 1'b0;
            aborted_q  <= 1'b0;
            err_q      <= 1'b0;
        end else if (start_ok) begin
            overflow_q <= 1'b0;
            aborted_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (start_bad) begin
                err_q <= 1'b1;
            end
            if ((state == ST_RUN) && fifo_full_sync) begin
                overflow_q <= 1'b1;
            end
            if (i_abort && ((state == ST_ARMED) || ((state == ST_RUN) && !(beat_fire && cap_last)))) begin
                aborted_q <= 1'b1;
            end
        end
    end

    assign o_busy     = (state != ST_IDLE);
    assign o_overflow = overflow_q;
    assign o_aborted  = aborted_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb/tb_adc_capture_ctrl.sv - directed vector bench for adc_capture_ctrl
module tb_adc_capture_ctrl;

    typedef struct {
        int pkt_len;
        int num_pkts;
        int extra;
        bit bp;
        int exp_beats;
    } vec_t;

    logic        m_axis_aclk = 1'b0;
    logic        m_axis_aresetn;
    logic        i_start;
    logic        i_abort;
    logic        i_trig_en;
    logic        i_trig;
    logic [15:0] i_pkt_len;
    logic [15:0] i_num_pkts;
    logic        i_fifo_full;
    logic        o_con_adcside;
    logic        o_con_axisside;
    logic        s_axis_tvalid;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tready;
    logic        m_axis_tvalid;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        o_busy;
    logic        o_done;
    logic        o_overflow;
    logic        o_aborted;
    logic        o_err;

    int unsigned src_idx   = 0;
    int unsigned src_limit = 0;
    bit          bp_en     = 1'b0;
    logic [64:0] beat_q[$];
    int          done_cnt   = 0;
    int          stab_err   = 0;
    logic        prev_stall = 1'b0;
    logic        prev_tlast = 1'b0;
    int          n_pass     = 0;
    int          n_total    = 0;
    vec_t        vecs[5];

    always #4 m_axis_aclk = ~m_axis_aclk;

    adc_capture_ctrl #(.CNT_W(16), .FLUSH_IDLE(8)) dut (
        .m_axis_aclk    (m_axis_aclk),
        .m_axis_aresetn (m_axis_aresetn),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .i_trig_en      (i_trig_en),
        .i_trig         (i_trig),
        .i_pkt_len      (i_pkt_len),
        .i_num_pkts     (i_num_pkts),
        .i_fifo_full    (i_fifo_full),
        .o_con_adcside  (o_con_adcside),
        .o_con_axisside (o_con_axisside),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_overflow     (o_overflow),
        .o_aborted      (o_aborted),
        .o_err          (o_err)
    );

    // Source model: a FIFO holding words src_idx .. src_limit-1.
    assign s_axis_tvalid = (src_idx < src_limit);
    assign s_axis_tdata  = 64'hD000_0000_0000_0000 | 64'(src_idx);

    always @(posedge m_axis_aclk) begin
        if (s_axis_tvalid && s_axis_tready) src_idx <= src_idx + 1;
    end

    always @(posedge m_axis_aclk) begin
        #1;
        m_axis_tready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Downstream monitor, sampled mid-cycle.
    always @(negedge m_axis_aclk) begin
        if (m_axis_tvalid && m_axis_tready) beat_q.push_back({m_axis_tlast, m_axis_tdata});
        if (prev_stall && m_axis_tvalid && (m_axis_tlast != prev_tlast)) stab_err <= stab_err + 1;
        prev_stall <= m_axis_tvalid && !m_axis_tready;
        prev_tlast <= m_axis_tlast;
        if (o_done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge m_axis_aclk);
        #1;
    endtask

    task automatic pulse_start(input int len, input int num, input bit ten);
        i_pkt_len  = 16'(len);
        i_num_pkts = 16'(num);
        i_trig_en  = ten;
        i_start    = 1'b1;
        tick();
        i_start    = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge m_axis_aclk);
            if (o_done) seen = 1'b1;
        end
        check({name, " done seen"}, 64'(seen), 64'd1);
        check({name, " busy during done"}, 64'(o_busy), 64'd1);
        tick();
        check({name, " busy/done after"}, {62'd0, o_busy, o_done}, 64'd0);
    endtask

    task automatic wait_run(input string name);
        for (int c = 0; c < 20 && !o_con_adcside; c++) tick();
        check({name, " reached run"}, 64'(o_con_adcside), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int unsigned base = src_idx;
        int q0 = beat_q.size();
        int d0 = done_cnt;
        int s0 = stab_err;
        int nb, derr, terr, tl;
        string nm = $sformatf("vec%0d", id);
        bp_en     = v.bp;
        src_limit = base + 32'(v.exp_beats + v.extra);
        pulse_start(v.pkt_len, v.num_pkts, 1'b0);
        check({nm, " sticky cleared"}, {61'd0, o_overflow, o_aborted, o_err}, 64'd0);
        wait_done(nm);
        bp_en = 1'b0;
        nb = beat_q.size() - q0;
        derr = 0; terr = 0; tl = 0;
        for (int k = 0; k < nb; k++) begin
            logic [64:0] e = beat_q[q0 + k];
            if (e[63:0] != (64'hD000_0000_0000_0000 | 64'(base + 32'(k)))) derr++;
            if (e[64] != (((k + 1) % v.pkt_len) == 0)) terr++;
            if (e[64]) tl++;
        end
        check({nm, " beats"}, 64'(nb), 64'(v.exp_beats));
        check({nm, " data order"}, 64'(derr), 64'd0);
        check({nm, " tlast position"}, 64'(terr), 64'd0);
        check({nm, " tlast count"}, 64'(tl), 64'(v.num_pkts));
        check({nm, " flushed"}, 64'(src_idx), 64'(src_limit));
        check({nm, " done pulses"}, 64'(done_cnt - d0), 64'd1);
        check({nm, " tlast stable"}, 64'(stab_err - s0), 64'd0);
    endtask

    task automatic run_abort(input int len, input int k, input bit exp_ab);
        int q0 = beat_q.size();
        int tl = 0;
        string nm = $sformatf("abort len%0d beat%0d", len, k);
        src_limit = src_idx + 20;
        pulse_start(len, 1, 1'b0);
        wait_run(nm);
        repeat (k - 1) tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        wait_done(nm);
        for (int j = q0; j < beat_q.size(); j++) if (beat_q[j][64]) tl++;
        check({nm, " beats"}, 64'(beat_q.size() - q0), 64'(k));
        check({nm, " tlast count"}, 64'(tl), (k == len) ? 64'd1 : 64'd0);
        check({nm, " aborted flag"}, 64'(o_aborted), 64'(exp_ab));
        check({nm, " flushed"}, 64'(src_idx), 64'(src_limit));
    endtask

    initial begin
        int q0;
        int con_seen;
        int lat;

        vecs[0] = '{1, 1, 2, 1'b0, 1};
        vecs[1] = '{4, 3, 3, 1'b0, 12};
        vecs[2] = '{5, 2, 4, 1'b1, 10};
        vecs[3] = '{3, 2, 0, 1'b1, 6};
        vecs[4] = '{2, 4, 1, 1'b0, 8};

        m_axis_aresetn = 1'b0;
        i_start = 1'b0; i_abort = 1'b0; i_trig_en = 1'b0; i_trig = 1'b0;
        i_pkt_len = '0; i_num_pkts = '0; i_fifo_full = 1'b0;
        #20;
        check("reset outputs", {54'd0, o_con_adcside, o_con_axisside, s_axis_tready, m_axis_tvalid,
              m_axis_tlast, o_busy, o_done, o_overflow, o_aborted, o_err}, 64'd0);
        @(negedge m_axis_aclk);
        m_axis_aresetn = 1'b1;
        tick();

        // Zero length or zero count is rejected and leaves the sequencer idle.
        pulse_start(0, 3, 1'b0);
        repeat (3) tick();
        check("err len0", 64'(o_err), 64'd1);
        check("err len0 idle", {61'd0, o_busy, o_con_adcside, o_con_axisside}, 64'd0);
        pulse_start(3, 0, 1'b0);
        tick();
        check("err num0", {62'd0, o_err, o_busy}, 64'd2);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Trigger wait: nothing moves until the trigger rises, then 4 cycles to enable.
        q0 = beat_q.size();
        src_limit = src_idx + 3;
        pulse_start(2, 1, 1'b1);
        con_seen = 0;
        repeat (50) begin
            tick();
            if (o_con_adcside || o_con_axisside) con_seen++;
        end
        check("trig wait controls", 64'(con_seen), 64'd0);
        check("trig wait beats", 64'(beat_q.size() - q0), 64'd0);
        check("trig wait busy", 64'(o_busy), 64'd1);
        i_trig = 1'b1;
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            tick();
            if (o_con_adcside) lat = c;
        end
        check("trig latency", 64'(lat), 64'd4);
        wait_done("trig");
        check("trig beats", 64'(beat_q.size() - q0), 64'd2);
        i_trig = 1'b0;

        // Abort mid-packet, abort on the final beat, then a clean start clears the flag.
        run_abort(8, 2, 1'b1);
        run_abort(2, 2, 1'b0);
        run_abort(8, 2, 1'b1);
        run_vec(vecs[1], 9);

        // Overflow is synchronized, sticky through DONE.
        q0 = beat_q.size();
        src_limit = src_idx;
        pulse_start(4, 1, 1'b0);
        wait_run("ovf");
        i_fifo_full = 1'b1;
        tick();
        check("ovf not yet", 64'(o_overflow), 64'd0);
        tick();
        tick();
        check("ovf set", 64'(o_overflow), 64'd1);
        i_fifo_full = 1'b0;
        src_limit = src_idx + 6;
        wait_done("ovf");
        check("ovf beats", 64'(beat_q.size() - q0), 64'd4);
        check("ovf sticky", 64'(o_overflow), 64'd1);

        // Asynchronous reset in the middle of a run.
        src_limit = src_idx + 50;
        pulse_start(100, 1, 1'b0);
        check("rst pre start clears ovf", 64'(o_overflow), 64'd0);
        wait_run("rst");
        check("rst pre active", {61'd0, o_busy, m_axis_tvalid, s_axis_tready}, 64'd7);
        #1;
        m_axis_aresetn = 1'b0;
        #1;
        check("rst async outputs", {54'd0, o_con_adcside, o_con_axisside, s_axis_tready, m_axis_tvalid,
              m_axis_tlast, o_busy, o_done, o_overflow, o_aborted, o_err}, 64'd0);
        check("rst async tdata", m_axis_tdata, 64'd0);
        @(negedge m_axis_aclk);
        m_axis_aresetn = 1'b1;
        tick();
        check("rst idle after", 64'(o_busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
